// File: rtl/piler_core.sv
// piler_core: gravity-drop engine for a column-stacked game field.
// One piece drops into column i_pile_col. The updated field bitmap and the updated
// column heights are registered one cycle after the inputs are sampled. o_valid
// flags a legal drop.
// Optional build macro PILER_FULL_FLAG_EN adds the registered o_full output, which
// reports a full board (every column at ROW_COUNT or above after the drop).
module piler_core #(
    parameter int COL_COUNT             = 7,
    parameter int ROW_COUNT             = 6,
    parameter int COUNT_W               = 3,
    parameter int COL_W                 = 3,
    parameter int FIELD_SIZE            = ROW_COUNT * COL_COUNT,
    parameter int PILE_COUNT_ARRAY_SIZE = COL_COUNT * COUNT_W
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [FIELD_SIZE-1:0]            i_field,
    input  logic [PILE_COUNT_ARRAY_SIZE-1:0] i_pile_count_array,
    input  logic [COL_W-1:0]                 i_pile_col,
`ifdef PILER_FULL_FLAG_EN
    output logic                             o_full,
`endif
    output logic                             o_valid,
    output logic [FIELD_SIZE-1:0]            o_field,
    output logic [PILE_COUNT_ARRAY_SIZE-1:0] o_pile_count_array
);

    localparam logic [COUNT_W-1:0] ROW_LIMIT = COUNT_W'(ROW_COUNT);

    logic [COUNT_W-1:0]               col_h [COL_COUNT];
    logic [COUNT_W-1:0]               next_h [COL_COUNT];
    logic [COL_COUNT-1:0]             col_hit;
    logic [COL_COUNT-1:0]             col_room;
    logic                             drop_legal;
    logic [FIELD_SIZE-1:0]            next_field;
    logic [PILE_COUNT_ARRAY_SIZE-1:0] next_pile;

    // A drop is legal only into an in-range column that still has room. Heights
    // above ROW_COUNT count as full, so they never wrap.
    assign drop_legal = |(col_hit & col_room);

    genvar c, r;
    generate
        for (c = 0; c < COL_COUNT; c++) begin : g_col
            assign col_h[c]    = i_pile_count_array[c*COUNT_W +: COUNT_W];
            // An out-of-range column index never matches, so it needs no separate test.
            assign col_hit[c]  = (i_pile_col == COL_W'(c));
            assign col_room[c] = (col_h[c] < ROW_LIMIT);
            assign next_h[c]   = (drop_legal && col_hit[c]) ? (col_h[c] + COUNT_W'(1)) : col_h[c];
            assign next_pile[c*COUNT_W +: COUNT_W] = next_h[c];

            for (r = 0; r < ROW_COUNT; r++) begin : g_row
                // OR-in keeps an already-set target bit at 1 when the input is inconsistent.
                assign next_field[r*COL_COUNT + c] = i_field[r*COL_COUNT + c]
                    | (drop_legal && col_hit[c] && (col_h[c] == COUNT_W'(r)));
            end
        end
    endgenerate

`ifdef PILER_FULL_FLAG_EN
    logic [COL_COUNT-1:0] col_full;

    generate
        for (c = 0; c < COL_COUNT; c++) begin : g_full
            // After an illegal drop next_h equals the input heights, so the same term serves both cases.
            assign col_full[c] = (next_h[c] >= ROW_LIMIT);
        end
    endgenerate

    // Register the board-full flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_full <= 1'b0;
        end else begin
            o_full <= &col_full;
        end
    end
`endif

    // Register the drop result every cycle; there is no handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid            <= 1'b0;
            o_field            <= '0;
            o_pile_count_array <= '0;
        end else begin
            o_valid            <= drop_legal;
            o_field            <= next_field;
            o_pile_count_array <= next_pile;
        end
    end

endmodule

// File: tb/tb_piler_core.sv
// Directed bench for piler_core. Build with PILER_FULL_FLAG_EN defined to include
// the checks on o_full.
module tb_piler_core;

    logic        clk;
    logic        rst_n;
    logic [41:0] field_in;
    logic [20:0] pile_in;
    logic [2:0]  col_in;
    logic        valid_out;
    logic [41:0] field_out;
    logic [20:0] pile_out;
`ifdef PILER_FULL_FLAG_EN
    logic        full_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    piler_core dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_field            (field_in),
        .i_pile_count_array (pile_in),
        .i_pile_col         (col_in),
`ifdef PILER_FULL_FLAG_EN
        .o_full             (full_out),
`endif
        .o_valid            (valid_out),
        .o_field            (field_out),
        .o_pile_count_array (pile_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one drop and sample the registered result shortly after the capturing edge.
    task automatic drop(input logic [41:0] f, input logic [20:0] p, input logic [2:0] c);
        field_in = f;
        pile_in  = p;
        col_in   = c;
        @(posedge clk);
        #1;
    endtask

    logic [41:0] cur_f;
    logic [20:0] cur_p;
    int          bad;

    initial begin
        rst_n    = 1'b0;
        field_in = '0;
        pile_in  = '0;
        col_in   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, valid_out}, 64'd0);
        chk("rst_field", {22'd0, field_out}, 64'd0);
        chk("rst_pile",  {43'd0, pile_out}, 64'd0);
        rst_n = 1'b1;

        // Empty board, column 0.
        drop(42'h0, 21'h0, 3'd0);
        chk("empty_valid", {63'd0, valid_out}, 64'd1);
        chk("empty_field", {22'd0, field_out}, 64'h1);
        chk("empty_pile",  {43'd0, pile_out}, 64'h1);

        // Column 3 at height 2, column 0 at height 1.
        drop(42'h409, 21'h401, 3'd3);
        chk("c3_valid", {63'd0, valid_out}, 64'd1);
        chk("c3_field", {22'd0, field_out}, 64'h20409);
        chk("c3_pile",  {43'd0, pile_out}, 64'h601);

        // Column 5 is full.
        drop(42'h0AB_CDEF_0123, 21'h30000, 3'd5);
        chk("c5full_valid", {63'd0, valid_out}, 64'd0);
        chk("c5full_field", {22'd0, field_out}, 64'h0AB_CDEF_0123);
        chk("c5full_pile",  {43'd0, pile_out}, 64'h30000);

        // Column index 7 is out of range.
        drop(42'h409, 21'h401, 3'd7);
        chk("c7_valid", {63'd0, valid_out}, 64'd0);
        chk("c7_field", {22'd0, field_out}, 64'h409);
        chk("c7_pile",  {43'd0, pile_out}, 64'h401);

        // Height 7 (above ROW_COUNT) must be treated as full, with no wrap to 0.
        drop(42'h0, 21'h1C0, 3'd2);
        chk("h7_valid", {63'd0, valid_out}, 64'd0);
        chk("h7_pile",  {43'd0, pile_out}, 64'h1C0);
        chk("h7_field", {22'd0, field_out}, 64'h0);

        // Target bit already set: the bit stays 1 and the height still increments.
        drop(42'h2, 21'h0, 3'd1);
        chk("dup_valid", {63'd0, valid_out}, 64'd1);
        chk("dup_field", {22'd0, field_out}, 64'h2);
        chk("dup_pile",  {43'd0, pile_out}, 64'h8);

        // Top row of the last column: bit 41 is set.
        drop(42'h0, 21'h140000, 3'd6);
        chk("top_valid", {63'd0, valid_out}, 64'd1);
        chk("top_field", {22'd0, field_out}, 64'h200_0000_0000);
        chk("top_pile",  {43'd0, pile_out}, 64'h180000);

        // Asynchronous reset takes effect between clock edges.
        drop(42'h0, 21'h0, 3'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, valid_out}, 64'd0);
        chk("arst_field", {22'd0, field_out}, 64'd0);
        chk("arst_pile",  {43'd0, pile_out}, 64'd0);
        @(posedge clk);
        #1;
        chk("arst_hold", {63'd0, valid_out}, 64'd0);
        rst_n = 1'b1;

        // Sweep: fill the board column by column, feeding each result back in.
        cur_f = '0;
        cur_p = '0;
        bad   = 0;
        for (int i = 0; i < 42; i++) begin
            drop(cur_f, cur_p, 3'(i % 7));
            if (valid_out) begin
                cur_f = field_out;
                cur_p = pile_out;
            end else begin
                bad++;
            end
`ifdef PILER_FULL_FLAG_EN
            if (i == 40) chk("full_early", {63'd0, full_out}, 64'd0);
`endif
        end
        chk("sweep_bad",   bad, 64'd0);
        chk("sweep_field", {22'd0, field_out}, 64'h3FF_FFFF_FFFF);
        chk("sweep_pile",  {43'd0, pile_out}, 64'h1B6DB6);
`ifdef PILER_FULL_FLAG_EN
        chk("sweep_full", {63'd0, full_out}, 64'd1);
`endif
        for (int c = 0; c < 7; c++) begin
            drop(cur_f, cur_p, 3'(c));
            chk($sformatf("full_col%0d_valid", c), {63'd0, valid_out}, 64'd0);
        end
        chk("full_field_kept", {22'd0, field_out}, 64'h3FF_FFFF_FFFF);
`ifdef PILER_FULL_FLAG_EN
        chk("full_illegal", {63'd0, full_out}, 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
